// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to IMEM word writer with core hold
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 256,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        load_done,
   output logic        load_err,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
   } state_t;

   // One extra bit so a 16-bit length can be compared against DEPTH without truncation.
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  chk_q, chk_d;
   logic [1:0]  lane_q, lane_d;
   logic [23:0] word_q, word_d;
   logic        in_ready_q, in_ready_d;
   logic        imem_we_q, imem_we_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic [31:0] imem_wdata_q, imem_wdata_d;
   logic        core_hold_q, core_hold_d;
   logic        load_done_q, load_done_d;
   logic        load_err_q, load_err_d;
   logic [15:0] words_loaded_q, words_loaded_d;
   logic        accept;

   // Frame parser: next state, checksum, word assembly and write strobe generation.
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      chk_d          = chk_q;
      lane_d         = lane_q;
      word_d         = word_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr_q;
      imem_wdata_d   = imem_wdata_q;
      words_loaded_d = words_loaded_q;
      accept         = in_valid && in_ready_q;

      case (state_q)
         S_IDLE: begin
            if (accept && (in_data == SYNC_BYTE)) begin
               state_d = S_LEN_LO;
               chk_d   = 8'd0;
               lane_d  = 2'd0;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = in_data;
               chk_d      = chk_q ^ in_data;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d = {in_data, len_q[7:0]};
               chk_d = chk_q ^ in_data;
               if ({1'b0, len_d} > DEPTH_W) begin
                  state_d = S_ERR;
               end else if (len_d == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               chk_d = chk_q ^ in_data;
               if (lane_q == 2'd3) begin
                  // Address uses the count before this word is added.
                  imem_we_d      = 1'b1;
                  imem_wdata_d   = {in_data, word_q};
                  imem_addr_d    = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
                  words_loaded_d = words_loaded_q + 16'd1;
                  lane_d         = 2'd0;
                  if (words_loaded_d == len_q) begin
                     state_d = S_CHECK;
                  end
               end else begin
                  case (lane_q)
                     2'd0:    word_d[7:0]   = in_data;
                     2'd1:    word_d[15:8]  = in_data;
                     default: word_d[23:16] = in_data;
                  endcase
                  lane_d = lane_q + 2'd1;
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (in_data == chk_q) ? S_DONE : S_ERR;
            end
         end
         default: ;
      endcase

      // Status outputs follow the state being entered so they change with it.
      in_ready_d  = (state_d != S_DONE) && (state_d != S_ERR);
      core_hold_d = (state_d != S_DONE);
      load_done_d = (state_d == S_DONE);
      load_err_d  = (state_d == S_ERR);
   end

   // State and registered outputs; reset drops any partial frame immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         len_q          <= 16'd0;
         chk_q          <= 8'd0;
         lane_q         <= 2'd0;
         word_q         <= 24'd0;
         in_ready_q     <= 1'b0;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= BASE_ADDR;
         imem_wdata_q   <= 32'd0;
         core_hold_q    <= 1'b1;
         load_done_q    <= 1'b0;
         load_err_q     <= 1'b0;
         words_loaded_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         chk_q          <= chk_d;
         lane_q         <= lane_d;
         word_q         <= word_d;
         in_ready_q     <= in_ready_d;
         imem_we_q      <= imem_we_d;
         imem_addr_q    <= imem_addr_d;
         imem_wdata_q   <= imem_wdata_d;
         core_hold_q    <= core_hold_d;
         load_done_q    <= load_done_d;
         load_err_q     <= load_err_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign core_hold    = core_hold_q;
   assign load_done    = load_done_q;
   assign load_err     = load_err_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 256;
   localparam logic [7:0]  SYNC  = 8'hA5;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, imem_we, core_hold, load_done, load_err;
   logic [31:0] imem_addr, imem_wdata;
   logic [15:0] words_loaded;

   int checks = 0;
   int passes = 0;

   logic [7:0]  tx[$];
   logic [31:0] mon_addr[$], mon_data[$];
   logic [31:0] exp_addr[$], exp_data[$];
   logic [31:0] sav_addr[$], sav_data[$];
   logic        exp_done, exp_err;
   int          we_double = 0;
   int          both_seen = 0;
   logic        we_prev = 1'b0;

   imem_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_hold(core_hold), .load_done(load_done),
      .load_err(load_err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // IMEM write monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         mon_addr.push_back(imem_addr);
         mon_data.push_back(imem_wdata);
      end
      if (imem_we === 1'b1 && we_prev === 1'b1) we_double++;
      if (load_done === 1'b1 && load_err === 1'b1) both_seen++;
      we_prev = imem_we;
   end

   // Reference: parse the byte list by the frame rules and list the expected writes and outcome.
   function automatic void model_frame(input logic [7:0] f[$]);
      int i, len, j;
      logic [7:0] c;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      i = 0;
      while (i < f.size() && f[i] != SYNC) i++;
      if (i + 2 >= f.size()) return;
      len = int'({f[i+2], f[i+1]});
      if (len > DEPTH) begin
         exp_err = 1'b1;
         return;
      end
      c = f[i+1] ^ f[i+2];
      for (int w = 0; w < len; w++) begin
         j = i + 3 + 4 * w;
         if (j + 3 < f.size()) begin
            exp_addr.push_back(BASE + 32'(4 * w));
            exp_data.push_back({f[j+3], f[j+2], f[j+1], f[j]});
            c = c ^ f[j] ^ f[j+1] ^ f[j+2] ^ f[j+3];
         end
      end
      j = i + 3 + 4 * len;
      if (j < f.size()) begin
         exp_done = (f[j] == c);
         exp_err  = (f[j] != c);
      end
   endfunction

   task automatic make_frame(input int len, input bit bad);
      logic [7:0] c, b;
      logic [15:0] l;
      l = 16'(len);
      tx.delete();
      tx.push_back(SYNC);
      tx.push_back(l[7:0]);
      tx.push_back(l[15:8]);
      c = l[7:0] ^ l[15:8];
      for (int i = 0; i < 4 * len; i++) begin
         b = 8'($urandom);
         tx.push_back(b);
         c = c ^ b;
      end
      tx.push_back(bad ? ~c : c);
   endtask

   task automatic apply_reset();
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap, t;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      in_data = b;
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", in_ready, t);
         in_valid = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   // Drives tx, then compares every write and the final status against the model.
   task automatic run_frame_case(input string name, input int maxgap, input bit do_reset);
      if (do_reset) apply_reset();
      mon_addr.delete();
      mon_data.delete();
      we_double = 0;
      both_seen = 0;
      foreach (tx[i]) send_byte(tx[i], maxgap);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      model_frame(tx);
      checks++;
      if (mon_addr.size() !== exp_addr.size())
         $display("FAIL %s write_count: got %0d required %0d", name, mon_addr.size(), exp_addr.size());
      else passes++;
      for (int k = 0; k < exp_addr.size() && k < mon_addr.size(); k++) begin
         checks++;
         if (mon_addr[k] !== exp_addr[k] || mon_data[k] !== exp_data[k])
            $display("FAIL %s write%0d: got %h@%h required %h@%h", name, k,
                     mon_data[k], mon_addr[k], exp_data[k], exp_addr[k]);
         else passes++;
      end
      checks++;
      if (load_done !== exp_done || load_err !== exp_err || core_hold !== !exp_done)
         $display("FAIL %s status: done/err/hold got %b%b%b required %b%b%b", name,
                  load_done, load_err, core_hold, exp_done, exp_err, !exp_done);
      else passes++;
      checks++;
      if (words_loaded !== 16'(exp_addr.size()))
         $display("FAIL %s words_loaded: got %0d required %0d", name, words_loaded, exp_addr.size());
      else passes++;
      checks++;
      if (we_double !== 0 || both_seen !== 0)
         $display("FAIL %s pulses: we_double=%0d both_seen=%0d required 0 and 0", name, we_double, both_seen);
      else passes++;
      checks++;
      if ((exp_done || exp_err) && in_ready !== 1'b0)
         $display("FAIL %s in_ready_end: got %b required 0", name, in_ready);
      else passes++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== BASE || imem_wdata !== 32'd0 ||
          core_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || words_loaded !== 16'd0)
         $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b wl=%0d required 0 0 %h 0 1 0 0 0",
                  in_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_err, words_loaded, BASE);
      else passes++;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || core_hold !== 1'b1)
         $display("FAIL idle_ready: in_ready=%b core_hold=%b required 1 1", in_ready, core_hold);
      else passes++;
   endtask

   task automatic test_spec_frame();
      logic [7:0] f [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
      tx.delete();
      foreach (f[i]) tx.push_back(f[i]);
      run_frame_case("spec_frame", 0, 1'b1);
      checks++;
      if (load_done !== 1'b1 || mon_data.size() != 2 || mon_data[1] !== 32'h0010_0093 || mon_addr[1] !== 32'h4)
         $display("FAIL spec_frame_fixed: done=%b writes=%0d required done=1 and 00100093@00000004",
                  load_done, mon_data.size());
      else passes++;
   endtask

   task automatic test_bad_checksum();
      tx[tx.size() - 1] = 8'h00;
      run_frame_case("bad_checksum", 0, 1'b1);
      checks++;
      if (load_err !== 1'b1 || core_hold !== 1'b1 || mon_addr.size() != 2)
         $display("FAIL bad_checksum_fixed: err=%b hold=%b writes=%0d required 1 1 2",
                  load_err, core_hold, mon_addr.size());
      else passes++;
   endtask

   task automatic test_garbage_len0();
      logic [7:0] f [7] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
      tx.delete();
      foreach (f[i]) tx.push_back(f[i]);
      run_frame_case("garbage_len0", 1, 1'b1);
   endtask

   task automatic test_len_overflow();
      tx.delete();
      tx.push_back(SYNC);
      tx.push_back(8'h01);
      tx.push_back(8'h01);
      run_frame_case("len_overflow", 0, 1'b1);
   endtask

   task automatic test_len_max();
      make_frame(DEPTH, 1'b0);
      run_frame_case("len_max", 0, 1'b1);
   endtask

   task automatic test_gaps();
      make_frame(4, 1'b0);
      run_frame_case("gapless", 0, 1'b1);
      sav_addr = mon_addr;
      sav_data = mon_data;
      run_frame_case("gapped", 4, 1'b1);
      checks++;
      if (mon_addr != sav_addr || mon_data != sav_data || mon_addr.size() != 4)
         $display("FAIL gap_compare: gapped writes=%0d differ from gapless writes=%0d (required identical, 4)",
                  mon_addr.size(), sav_addr.size());
      else passes++;
   endtask

   task automatic test_reset_midframe();
      apply_reset();
      make_frame(2, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(tx[i], 0);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || imem_we !== 1'b0 || core_hold !== 1'b1 || words_loaded !== 16'd0 ||
          load_done !== 1'b0 || load_err !== 1'b0 || imem_addr !== BASE)
         $display("FAIL midframe_reset: rdy=%b we=%b hold=%b wl=%0d done=%b err=%b addr=%h required 0 0 1 0 0 0 %h",
                  in_ready, imem_we, core_hold, words_loaded, load_done, load_err, imem_addr, BASE);
      else passes++;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      make_frame(3, 1'b0);
      run_frame_case("after_reset", 2, 1'b0);
   endtask

   task automatic test_random();
      int len;
      bit bad;
      for (int r = 0; r < 6; r++) begin
         len = int'($urandom_range(8, 0));
         bad = ($urandom_range(3, 0) == 0);
         make_frame(len, bad);
         for (int g = int'($urandom_range(3, 0)); g > 0; g--) begin
            logic [7:0] gb;
            gb = 8'($urandom);
            if (gb == SYNC) gb = 8'h00;
            tx.push_front(gb);
         end
         run_frame_case($sformatf("random%0d", r), int'($urandom_range(3, 0)), 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_spec_frame();
      test_bad_checksum();
      test_garbage_len0();
      test_len_overflow();
      test_len_max();
      test_gaps();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
